// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: oversample, bit-centre and bit-end ticks from a runtime divisor.
// Define UART_BAUD_FRAC_EN to enable the fractional accumulator; otherwise the period is div_int.
module uart_baud_gen_frac #(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned FRAC_WIDTH   = 4,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DEF_DIV_INT  = 27,
  parameter int unsigned DEF_DIV_FRAC = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sync,
  input  logic                  div_load,
  input  logic [DIV_WIDTH-1:0]  div_int_in,
  input  logic [FRAC_WIDTH-1:0] div_frac_in,
  output logic                  os_tick,
  output logic                  mid_tick,
  output logic                  baud_tick,
  output logic                  cfg_err
);

  localparam int unsigned OsW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0] OsMid  = OsW'(OVERSAMPLE / 2 - 1);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_int_q;
  logic [DIV_WIDTH-1:0] shd_int_q;
  logic [OsW-1:0]       os_cnt_q;
  logic                 pending_q;
  logic [DIV_WIDTH-1:0] period_m1;
  logic                 load_ok;
  logic                 wrap;

  assign load_ok = div_load && (div_int_in > DIV_WIDTH'(1));

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_WIDTH-1:0] acc_q;
  logic [FRAC_WIDTH-1:0] div_frac_q;
  logic [FRAC_WIDTH-1:0] shd_frac_q;
  logic                  ext_q;
  logic [FRAC_WIDTH:0]   acc_sum;

  assign acc_sum   = {1'b0, acc_q} + {1'b0, div_frac_q};
  // div_int >= 2, so div_int - 1 + ext always fits in DIV_WIDTH bits
  assign period_m1 = div_int_q - DIV_WIDTH'(1) + DIV_WIDTH'(ext_q);
`else
  logic unused_frac;

  assign unused_frac = (^div_frac_in) ^ (DEF_DIV_FRAC != 0);
  assign period_m1   = div_int_q - DIV_WIDTH'(1);
`endif

  // Last enabled cycle of the current period; the registered tick appears on this edge.
  assign wrap = enable && (cnt_q == period_m1);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      os_cnt_q  <= '0;
      div_int_q <= DIV_WIDTH'(DEF_DIV_INT);
      shd_int_q <= DIV_WIDTH'(DEF_DIV_INT);
      pending_q <= 1'b0;
      cfg_err   <= 1'b0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
      acc_q      <= '0;
      ext_q      <= 1'b0;
      div_frac_q <= FRAC_WIDTH'(DEF_DIV_FRAC);
      shd_frac_q <= FRAC_WIDTH'(DEF_DIV_FRAC);
`endif
    end else begin
      if (div_load) begin
        cfg_err <= ~load_ok;
      end

      if (sync) begin
        cnt_q     <= '0;
        os_cnt_q  <= '0;
        os_tick   <= 1'b0;
        mid_tick  <= 1'b0;
        baud_tick <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
        acc_q <= '0;
        ext_q <= 1'b0;
`endif
        if (load_ok) begin
          div_int_q <= div_int_in;
          shd_int_q <= div_int_in;
          pending_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
          div_frac_q <= div_frac_in;
          shd_frac_q <= div_frac_in;
`endif
        end else if (pending_q) begin
          div_int_q <= shd_int_q;
          pending_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
          div_frac_q <= shd_frac_q;
`endif
        end
      end else begin
        os_tick   <= wrap;
        mid_tick  <= wrap && (os_cnt_q == OsMid);
        baud_tick <= wrap && (os_cnt_q == OsLast);

        if (enable) begin
          cnt_q <= wrap ? '0 : cnt_q + DIV_WIDTH'(1);
        end

        if (wrap) begin
          os_cnt_q <= (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
`ifdef UART_BAUD_FRAC_EN
          {ext_q, acc_q} <= acc_sum;
`endif
          if (pending_q) begin
            div_int_q <= shd_int_q;
            pending_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            div_frac_q <= shd_frac_q;
`endif
          end
        end

        // A load coinciding with an apply lands in the shadow after the old value moved out.
        if (load_ok) begin
          shd_int_q <= div_int_in;
          pending_q <= 1'b1;
`ifdef UART_BAUD_FRAC_EN
          shd_frac_q <= div_frac_in;
`endif
        end
      end
    end
  end

endmodule
